// File: rtl/nn_layer_seq.sv
// nn_layer_seq: time-multiplexed signed perceptron layer with one shared MAC.
// Weights, biases, thresholds and inputs stream in byte-serially; results leave
// as one packed vector under valid/ready.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-low
//   act_mode   0 = step output, 1 = thresholded saturating ReLU
//   cfg_*      parameter stream (valid/ready), cfg_done pulses after the last entry
//   in_*       input sample stream (valid/ready)
//   out_*      result vector (valid/ready), neuron n in bits [n*DW +: DW]
//   busy       high whenever the layer is not idle
module nn_layer_seq #(
   parameter int N_IN   = 4,
   parameter int N_NEUR = 4,
   parameter int DW     = 8,
   parameter int ACC_W  = 2*DW + $clog2(N_IN) + 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 act_mode,
   input  logic                 cfg_valid,
   input  logic [DW-1:0]        cfg_data,
   output logic                 cfg_ready,
   output logic                 cfg_done,
   input  logic                 in_valid,
   input  logic [DW-1:0]        in_data,
   output logic                 in_ready,
   output logic                 out_valid,
   output logic [N_NEUR*DW-1:0] out_data,
   input  logic                 out_ready,
   output logic                 busy
);

   localparam int IW = (N_IN > 1) ? $clog2(N_IN) : 1;
   localparam int NW = (N_NEUR > 1) ? $clog2(N_NEUR) : 1;
   localparam int KW = $clog2(N_IN + 2);
   localparam int PW = 2*DW;

   localparam logic [IW-1:0] I_LAST = IW'(N_IN - 1);
   localparam logic [NW-1:0] N_LAST = NW'(N_NEUR - 1);
   localparam logic [KW-1:0] K_BIAS = KW'(N_IN);
   localparam logic [KW-1:0] K_LAST = KW'(N_IN + 1);

   localparam logic signed [ACC_W-1:0] YMAX = ACC_W'((1 << (DW-1)) - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_COMP,
      S_OUT
   } state_t;

   state_t state_q;

   // parameter and sample storage
   logic signed [DW-1:0] w_q  [N_NEUR][N_IN];
   logic signed [DW-1:0] b_q  [N_NEUR];
   logic signed [DW-1:0] th_q [N_NEUR];
   logic signed [DW-1:0] x_q  [N_IN];

   // config write pointer split into neuron / entry-within-neuron
   logic [NW-1:0] cfg_n_q;
   logic [KW-1:0] cfg_k_q;
   logic          cfg_done_q;
   logic [IW-1:0] in_ptr_q;

   // MAC issue stage
   logic [NW-1:0] mac_n_q;
   logic [IW-1:0] mac_i_q;
   logic          issue_q;
   logic          mode_q;

   // product register and accumulate stage
   logic signed [PW-1:0]    prod_q;
   logic                    pv_q;
   logic                    plast_q;
   logic [NW-1:0]           pn_q;
   logic signed [ACC_W-1:0] acc_q;

   logic [N_NEUR*DW-1:0] out_data_q;
   logic                 out_valid_q;

   logic cfg_fire;
   logic in_fire;
   logic start_comp;

   logic signed [PW-1:0]    prod_d;
   logic signed [ACC_W-1:0] acc_d;
   logic signed [ACC_W-1:0] s_d;
   logic signed [ACC_W-1:0] th_ext;
   logic [DW-1:0]           y_d;

   // cfg has priority over input in IDLE; in_ready looks at cfg_valid only
   assign cfg_ready = (state_q == S_IDLE);
   assign in_ready  = ((state_q == S_IDLE) && !cfg_valid) ||
                      (state_q == S_LOAD);

   assign cfg_fire = cfg_valid && cfg_ready;
   assign in_fire  = in_valid && in_ready;

   // last sample of the vector accepted -> start the MAC pass
   assign start_comp = in_fire &&
      (((state_q == S_IDLE) && (N_IN == 1)) ||
       ((state_q == S_LOAD) && (in_ptr_q == I_LAST)));

   assign cfg_done  = cfg_done_q;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign busy      = (state_q != S_IDLE);

   always_comb begin
      prod_d = w_q[mac_n_q][mac_i_q] * x_q[mac_i_q];
      acc_d  = acc_q + {{(ACC_W-PW){prod_q[PW-1]}}, prod_q};
      s_d    = acc_d + {{(ACC_W-DW){b_q[pn_q][DW-1]}}, b_q[pn_q]};
      th_ext = {{(ACC_W-DW){th_q[pn_q][DW-1]}}, th_q[pn_q]};
      y_d    = '0;
      if (s_d > th_ext) begin
         if (!mode_q) begin
            y_d = DW'(1);
         end else if (s_d[ACC_W-1]) begin
            y_d = '0;
         end else if (s_d > YMAX) begin
            y_d = {1'b0, {(DW-1){1'b1}}};
         end else begin
            y_d = s_d[DW-1:0];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         for (int n = 0; n < N_NEUR; n++) begin
            for (int i = 0; i < N_IN; i++) begin
               w_q[n][i] <= '0;
            end
            b_q[n]  <= '0;
            th_q[n] <= '0;
         end
         for (int i = 0; i < N_IN; i++) begin
            x_q[i] <= '0;
         end
         cfg_n_q     <= '0;
         cfg_k_q     <= '0;
         cfg_done_q  <= 1'b0;
         in_ptr_q    <= '0;
         mac_n_q     <= '0;
         mac_i_q     <= '0;
         issue_q     <= 1'b0;
         mode_q      <= 1'b0;
         prod_q      <= '0;
         pv_q        <= 1'b0;
         plast_q     <= 1'b0;
         pn_q        <= '0;
         acc_q       <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
      end else begin
         cfg_done_q <= 1'b0;

         // parameter stream: w[0..N_IN-1], bias, threshold per neuron
         if (cfg_fire) begin
            if (cfg_k_q < K_BIAS) begin
               w_q[cfg_n_q][cfg_k_q[IW-1:0]] <= cfg_data;
            end else if (cfg_k_q == K_BIAS) begin
               b_q[cfg_n_q] <= cfg_data;
            end else begin
               th_q[cfg_n_q] <= cfg_data;
            end
            if (cfg_k_q == K_LAST) begin
               cfg_k_q <= '0;
               if (cfg_n_q == N_LAST) begin
                  cfg_n_q    <= '0;
                  cfg_done_q <= 1'b1;
               end else begin
                  cfg_n_q <= cfg_n_q + 1'b1;
               end
            end else begin
               cfg_k_q <= cfg_k_q + 1'b1;
            end
         end

         unique case (state_q)
            S_IDLE: begin
               if (in_fire) begin
                  x_q[0] <= in_data;
                  if (N_IN > 1) begin
                     in_ptr_q <= IW'(1);
                     state_q  <= S_LOAD;
                  end
               end
            end

            S_LOAD: begin
               if (in_fire) begin
                  x_q[in_ptr_q] <= in_data;
                  if (in_ptr_q == I_LAST) begin
                     in_ptr_q <= '0;
                  end else begin
                     in_ptr_q <= in_ptr_q + 1'b1;
                  end
               end
            end

            S_COMP: begin
               // issue one product per cycle, i inner, n outer
               if (issue_q) begin
                  prod_q  <= prod_d;
                  pv_q    <= 1'b1;
                  plast_q <= (mac_i_q == I_LAST);
                  pn_q    <= mac_n_q;
                  if (mac_i_q == I_LAST) begin
                     mac_i_q <= '0;
                     if (mac_n_q == N_LAST) begin
                        issue_q <= 1'b0;
                     end else begin
                        mac_n_q <= mac_n_q + 1'b1;
                     end
                  end else begin
                     mac_i_q <= mac_i_q + 1'b1;
                  end
               end else begin
                  pv_q <= 1'b0;
               end

               // accumulate one cycle behind the multiply
               if (pv_q) begin
                  if (plast_q) begin
                     out_data_q[int'(pn_q)*DW +: DW] <= y_d;
                     acc_q <= '0;
                     if (pn_q == N_LAST) begin
                        state_q     <= S_OUT;
                        out_valid_q <= 1'b1;
                     end
                  end else begin
                     acc_q <= acc_d;
                  end
               end
            end

            S_OUT: begin
               if (out_ready) begin
                  state_q     <= S_IDLE;
                  out_valid_q <= 1'b0;
               end
            end

            default: state_q <= S_IDLE;
         endcase

         if (start_comp) begin
            state_q <= S_COMP;
            mode_q  <= act_mode;
            issue_q <= 1'b1;
            mac_n_q <= '0;
            mac_i_q <= '0;
            pv_q    <= 1'b0;
            acc_q   <= '0;
         end
      end
   end

endmodule
